// File: rtl/arm_ctrl_fsm.sv
// Multi-cycle control sequencer for the non-pipelined ARM core.
// Owns PC, instruction register and CPSR NZCV; steps each instruction through
// FETCH -> DECODE -> EXEC -> MEM -> WB with ready/request memory handshakes.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   imem_req/addr/ready/rdata  instruction fetch handshake
//   inst, pc, flags            architectural state (instruction reg, PC, NZCV)
//   alu_flags                  ALU NZCV result, sampled in EXEC
//   dmem_req/we/ready          data access handshake
//   rf_we, rf_wsrc             register-file write strobe and source select
//   undef                      pulse when an unsupported class is skipped
module arm_ctrl_fsm #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic [3:0]  alu_flags,
    output logic [3:0]  flags,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic [1:0]  rf_wsrc,
    output logic        undef
);

    localparam int unsigned XLEN    = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] PC_AHEAD = XLEN'(8);
    localparam logic [1:0] WSRC_ALU  = 2'd0;
    localparam logic [1:0] WSRC_MEM  = 2'd1;
    localparam logic [1:0] WSRC_LINK = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Condition-code evaluation against NZCV (bit 3 = N).
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, p;
        {n, z, cf, v} = f;
        case (c)
            4'h0:    p = z;
            4'h1:    p = !z;
            4'h2:    p = cf;
            4'h3:    p = !cf;
            4'h4:    p = n;
            4'h5:    p = !n;
            4'h6:    p = v;
            4'h7:    p = !v;
            4'h8:    p = cf && !z;
            4'h9:    p = !cf || z;
            4'hA:    p = (n == v);
            4'hB:    p = (n != v);
            4'hC:    p = !z && (n == v);
            4'hD:    p = z || (n != v);
            4'hE:    p = 1'b1;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    function automatic logic is_dp(input logic [31:0] i);
        return i[27:26] == 2'b00;
    endfunction

    function automatic logic is_ls(input logic [31:0] i);
        return i[27:26] == 2'b01;
    endfunction

    function automatic logic is_br(input logic [31:0] i);
        return i[27:25] == 3'b101;
    endfunction

    state_t            r_state, w_state_nxt;
    logic [XLEN-1:0]   r_pc, w_pc_nxt;
    logic [XLEN-1:0]   r_inst, w_inst_nxt;
    logic [3:0]        r_flags, w_flags_nxt;
    logic              r_imem_req, r_dmem_req, r_dmem_we, r_rf_we, r_undef;
    logic [1:0]        r_rf_wsrc;
    logic              w_imem_req_nxt, w_dmem_req_nxt, w_dmem_we_nxt, w_rf_we_nxt, w_undef_nxt;
    logic [1:0]        w_rf_wsrc_nxt;
    logic              w_pass, w_unsup;
    logic [XLEN-1:0]   w_br_off;

    assign w_pass   = cond_pass(r_inst[31:28], r_flags);
    assign w_unsup  = !(is_dp(r_inst) || is_ls(r_inst) || is_br(r_inst));
    assign w_br_off = {{6{r_inst[23]}}, r_inst[23:0], 2'b00};

    // Architectural state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_inst     <= '0;
            r_flags    <= '0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_rf_we    <= 1'b0;
            r_rf_wsrc  <= WSRC_ALU;
            r_undef    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_inst     <= w_inst_nxt;
            r_flags    <= w_flags_nxt;
            r_imem_req <= w_imem_req_nxt;
            r_dmem_req <= w_dmem_req_nxt;
            r_dmem_we  <= w_dmem_we_nxt;
            r_rf_we    <= w_rf_we_nxt;
            r_rf_wsrc  <= w_rf_wsrc_nxt;
            r_undef    <= w_undef_nxt;
        end
    end

    // Next state plus the Moore outputs of the state being entered, so each
    // output register holds the decode of the state it is presented in.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_inst_nxt     = r_inst;
        w_flags_nxt    = r_flags;
        w_imem_req_nxt = 1'b0;
        w_dmem_req_nxt = 1'b0;
        w_dmem_we_nxt  = 1'b0;
        w_rf_we_nxt    = 1'b0;
        w_rf_wsrc_nxt  = WSRC_ALU;
        w_undef_nxt    = 1'b0;

        case (r_state)
            S_FETCH: begin
                // Ready only counts while the request is actually presented.
                if (r_imem_req && imem_ready) begin
                    w_inst_nxt  = imem_rdata;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!w_pass || w_unsup) begin
                    w_pc_nxt    = r_pc + PC_STEP;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_dp(r_inst)) begin
                    if (r_inst[20]) w_flags_nxt = alu_flags;
                    w_pc_nxt    = r_pc + PC_STEP;
                    w_state_nxt = S_FETCH;
                end else if (is_br(r_inst)) begin
                    w_pc_nxt    = r_pc + PC_AHEAD + w_br_off;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_MEM;
                end
            end
            S_MEM: begin
                if (r_dmem_req && dmem_ready) begin
                    if (r_inst[20]) begin
                        w_state_nxt = S_WB;
                    end else begin
                        w_pc_nxt    = r_pc + PC_STEP;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_WB: begin
                w_pc_nxt    = r_pc + PC_STEP;
                w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_FETCH;
        endcase

        case (w_state_nxt)
            S_FETCH:  w_imem_req_nxt = 1'b1;
            S_DECODE: w_undef_nxt = cond_pass(w_inst_nxt[31:28], w_flags_nxt)
                                    && !(is_dp(w_inst_nxt) || is_ls(w_inst_nxt) || is_br(w_inst_nxt));
            S_EXEC: begin
                if (is_dp(w_inst_nxt)) begin
                    // TST/TEQ/CMP/CMN (opcodes 10xx) only update flags.
                    w_rf_we_nxt = (w_inst_nxt[24:23] != 2'b10);
                end else if (is_br(w_inst_nxt) && w_inst_nxt[24]) begin
                    w_rf_we_nxt   = 1'b1;
                    w_rf_wsrc_nxt = WSRC_LINK;
                end
            end
            S_MEM: begin
                w_dmem_req_nxt = 1'b1;
                w_dmem_we_nxt  = !w_inst_nxt[20];
            end
            S_WB: begin
                w_rf_we_nxt   = 1'b1;
                w_rf_wsrc_nxt = WSRC_MEM;
            end
            default: ;
        endcase
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign inst      = r_inst;
    assign pc        = r_pc;
    assign flags     = r_flags;
    assign dmem_req  = r_dmem_req;
    assign dmem_we   = r_dmem_we;
    assign rf_we     = r_rf_we;
    assign rf_wsrc   = r_rf_wsrc;
    assign undef     = r_undef;

endmodule
